// File: rtl/lab4_branch_branch_gshare_ckpt.sv
// Gshare branch predictor with an in-order checkpoint FIFO.
// Predictions speculatively shift the global history; each resolution pops
// the oldest checkpoint, trains its counter, and on a misprediction flushes
// all younger work and rebuilds the history from the checkpoint.
module lab4_branch_branch_gshare_ckpt #(
  parameter int PHT_SIZE   = 2048,
  parameter int HIST_BITS  = 11,
  parameter int CTR_BITS   = 2,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pred_val,
  output logic                              pred_rdy,
  input  logic [31:0]                       pred_pc,
  output logic                              pred_taken,
  input  logic                              upd_val,
  input  logic                              upd_taken,
  output logic                              upd_mispred,
  output logic [$clog2(CKPT_DEPTH):0]       inflight,
  output logic [31:0]                       mispred_cnt
);

  localparam int IDX = $clog2(PHT_SIZE);
  localparam int PW  = $clog2(CKPT_DEPTH);
  localparam int IW  = PW + 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  // Append a new outcome bit; the concatenate-and-truncate form also covers a 1-bit history.
  function automatic logic [HIST_BITS-1:0] ghr_shift(input logic [HIST_BITS-1:0] g,
                                                     input logic b);
    logic [HIST_BITS:0] cat;
    cat = {g, b};
    return cat[HIST_BITS-1:0];
  endfunction

  // Saturating up/down step of a pattern history counter.
  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                   input logic up);
    if (up) return (c == '1) ? c : c + CTR_BITS'(1);
    else    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // Saturating increment of the misprediction counter.
  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  logic [CTR_BITS-1:0]  pht_q     [PHT_SIZE];
  logic [IDX-1:0]       ck_idx_q  [CKPT_DEPTH];
  logic [HIST_BITS-1:0] ck_ghr_q  [CKPT_DEPTH];
  logic                 ck_pred_q [CKPT_DEPTH];

  logic [HIST_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]        inflight_q, inflight_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;

  logic [IDX-1:0]       pred_idx;
  logic                 pop, push, full;
  logic [IDX-1:0]       head_idx;
  logic [HIST_BITS-1:0] head_ghr;
  logic                 head_pred;
  logic [CTR_BITS-1:0]  ctr_upd;
  logic                 unused_pc;

  assign unused_pc = ^{pred_pc[31:2+IDX], pred_pc[1:0]};

  // Prediction lookup, handshake, and next-state selection for history, pointers and counters.
  always_comb begin
    pred_idx      = pred_pc[2 +: IDX] ^ IDX'(spec_ghr_q);
    pred_taken    = pht_q[pred_idx][CTR_BITS-1];
    head_idx      = ck_idx_q[rd_ptr_q];
    head_ghr      = ck_ghr_q[rd_ptr_q];
    head_pred     = ck_pred_q[rd_ptr_q];
    ctr_upd       = ctr_next(pht_q[head_idx], upd_taken);
    pop           = upd_val && (inflight_q != '0);
    upd_mispred   = pop && (head_pred != upd_taken);
    full          = (inflight_q == IW'(CKPT_DEPTH));
    // A correct pop frees a slot in the same cycle, so a full FIFO can still accept.
    pred_rdy      = !upd_mispred && (!full || pop);
    push          = pred_val && pred_rdy;
    spec_ghr_d    = spec_ghr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = inflight_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_mispred) begin
      spec_ghr_d    = ghr_shift(head_ghr, upd_taken);
      rd_ptr_d      = wr_ptr_q;
      inflight_d    = '0;
      mispred_cnt_d = cnt_inc(mispred_cnt_q);
    end else begin
      if (push) begin
        spec_ghr_d = ghr_shift(spec_ghr_q, pred_taken);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      inflight_d = inflight_q + IW'(push) - IW'(pop);
    end
  end

  // Control state and counter table; reset wins over any concurrent request or update.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_ghr_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= CTR_INIT;
    end else begin
      spec_ghr_q    <= spec_ghr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (pop) pht_q[head_idx] <= ctr_upd;
    end
  end

  // Checkpoint payload; only meaningful between the pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ck_idx_q[wr_ptr_q]  <= pred_idx;
      ck_ghr_q[wr_ptr_q]  <= spec_ghr_q;
      ck_pred_q[wr_ptr_q] <= pred_taken;
    end
  end

  assign inflight    = inflight_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_lab4_branch_branch_gshare_ckpt.sv
// Directed bench for the gshare checkpoint predictor (default parameters).
module tb_lab4_branch_branch_gshare_ckpt;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_val;
  logic        pred_rdy;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_val;
  logic        upd_taken;
  logic        upd_mispred;
  logic [2:0]  inflight;
  logic [31:0] mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  lab4_branch_branch_gshare_ckpt dut (
    .clk         (clk),
    .reset       (reset),
    .pred_val    (pred_val),
    .pred_rdy    (pred_rdy),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .upd_val     (upd_val),
    .upd_taken   (upd_taken),
    .upd_mispred (upd_mispred),
    .inflight    (inflight),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        uv;
    logic        ut;
    logic        e_taken;
    logic        e_rdy;
    logic        e_mis;
    int          e_infl;
    int          e_cnt;
    int          e_ghr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Apply inputs just after a rising edge and wait for the falling edge to sample.
  task automatic drive(input logic pv, input logic [31:0] pc, input logic uv, input logic ut);
    pred_val  = pv;
    pred_pc   = pc;
    upd_val   = uv;
    upd_taken = ut;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pred_val = 1'b0; pred_pc = 32'h100; upd_val = 1'b0; upd_taken = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [10:0] g, gp;
    logic [1:0]  ctr_m;
    logic        p, up, mis;
    logic [31:0] pc;

    //          pv    pc          uv    ut    tk    rdy   mis  infl cnt ghr
    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 'h00};
    tbl[1] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 'h00};
    tbl[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 'h01};
    tbl[3] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 'h02};
    tbl[4] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2, 'h03};
    tbl[5] = '{1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 'h06};
    tbl[6] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 'h06};
    tbl[7] = '{1'b1, 32'h118, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 2, 'h06};
    tbl[8] = '{1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 'h0D};
    tbl[9] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 'h1A};

    do_reset();

    // Warm-up, empty update and pop+push, one vector per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].pv, tbl[i].pc, tbl[i].uv, tbl[i].ut);
      chk($sformatf("v%0d_taken", i), 32'(pred_taken),  32'(tbl[i].e_taken));
      chk($sformatf("v%0d_rdy", i),   32'(pred_rdy),    32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_mis", i),   32'(upd_mispred), 32'(tbl[i].e_mis));
      chk($sformatf("v%0d_infl", i),  32'(inflight),    tbl[i].e_infl);
      chk($sformatf("v%0d_cnt", i),   mispred_cnt,      tbl[i].e_cnt);
      chk($sformatf("v%0d_ghr", i),   32'(dut.spec_ghr_q), tbl[i].e_ghr);
      tick();
    end
    chk("pht_40", 32'(dut.pht_q[11'h040]), 3);
    chk("pht_41", 32'(dut.pht_q[11'h041]), 2);
    chk("pht_43", 32'(dut.pht_q[11'h043]), 0);
    chk("pht_46_untouched", 32'(dut.pht_q[11'h046]), 1);

    // Saturation on index 0x80: five taken then five not-taken resolutions.
    do_reset();
    g = '0;
    ctr_m = 2'd1;
    for (int k = 0; k < 10; k++) begin
      up = (k < 5);
      pc = 32'((11'h080 ^ g)) << 2;
      p  = ctr_m[1];
      drive(1'b1, pc, 1'b0, 1'b0);
      chk($sformatf("sat%0d_pred", k), 32'(pred_taken), 32'(p));
      tick();
      gp  = {g[9:0], p};
      mis = (p != up);
      drive(1'b0, pc, 1'b1, up);
      chk($sformatf("sat%0d_mis", k), 32'(upd_mispred), 32'(mis));
      tick();
      g = mis ? {g[9:0], up} : gp;
      if (up) ctr_m = (ctr_m == 2'd3) ? 2'd3 : ctr_m + 2'd1;
      else    ctr_m = (ctr_m == 2'd0) ? 2'd0 : ctr_m - 2'd1;
      chk($sformatf("sat%0d_ctr", k), 32'(dut.pht_q[11'h080]), 32'(ctr_m));
      if (k == 4) chk("sat_hi", 32'(dut.pht_q[11'h080]), 3);
    end
    chk("sat_lo", 32'(dut.pht_q[11'h080]), 0);

    // Full FIFO, then simultaneous correct pop and push while full.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      chk($sformatf("fill%0d_rdy", k), 32'(pred_rdy), 1);
      chk($sformatf("fill%0d_taken", k), 32'(pred_taken), 0);
      tick();
    end
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    chk("full_infl", 32'(inflight), 4);
    chk("full_rdy", 32'(pred_rdy), 0);
    tick();
    drive(1'b1, 32'h300, 1'b1, 1'b0);
    chk("full_still", 32'(inflight), 4);
    chk("full_poppush_rdy", 32'(pred_rdy), 1);
    chk("full_poppush_mis", 32'(upd_mispred), 0);
    tick();
    drive(1'b0, 32'h300, 1'b0, 1'b0);
    chk("full_after_poppush", 32'(inflight), 4);
    chk("full_pht_c0", 32'(dut.pht_q[11'h0C0]), 0);
    tick();

    // Mispredict recovery: build history 0x005 at the oldest checkpoint.
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h100, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h100, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h100, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    chk("rec_ghr5", 32'(dut.spec_ghr_q), 32'h005);
    chk("rec_cnt2", mispred_cnt, 2);
    tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    chk("rec_infl3", 32'(inflight), 3);
    chk("rec_mis", 32'(upd_mispred), 1);
    chk("rec_rdy0", 32'(pred_rdy), 0);
    tick();
    drive(1'b0, 32'h100, 1'b0, 1'b0);
    chk("rec_flush", 32'(inflight), 0);
    chk("rec_ghr_b", 32'(dut.spec_ghr_q), 32'h00B);
    chk("rec_cnt3", mispred_cnt, 3);
    chk("rec_pht45", 32'(dut.pht_q[11'h045]), 2);
    tick();

    // Reset with two in flight and a concurrent request.
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    pred_val = 1'b1;
    #1;
    chk("mid_infl2", 32'(inflight), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h100, 1'b0, 1'b0);
    chk("rst_infl", 32'(inflight), 0);
    chk("rst_ghr", 32'(dut.spec_ghr_q), 0);
    chk("rst_cnt", mispred_cnt, 0);
    chk("rst_rdy", 32'(pred_rdy), 1);
    chk("rst_taken", 32'(pred_taken), 0);
    chk("rst_pht45", 32'(dut.pht_q[11'h045]), 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
